// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register indices, exception
// codes, Status/Cause field positions and the EXL state encoding.
package cp0_pkg;

    localparam logic [31:0] PRID = 32'h0000_4D50;

    // Register indices (mfc0/mtc0 rd field)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // ExcCode values driven by the controller
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status / Cause field bit positions
    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } exl_state_t;

    // Assemble the architectural Status word; unimplemented bits read 0
    function automatic logic [31:0] pack_status(input logic [5:0] im,
                                                input logic exl,
                                                input logic ie);
        logic [31:0] v;
        v = 32'h0;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL] = exl;
        v[SR_IE]  = ie;
        return v;
    endfunction

    // Assemble the architectural Cause word; unimplemented bits read 0
    function automatic logic [31:0] pack_cause(input logic [5:0] ip,
                                               input logic [4:0] code);
        logic [31:0] v;
        v = 32'h0;
        v[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for cp0. Count free-runs and wraps; the pending bit
// sets when the freshly incremented Count equals Compare and clears on any
// write to Compare. A write to Count replaces that cycle's increment.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_a2,
    input  logic [31:0] i_din,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;
    logic [31:0] w_count_inc;
    logic        w_ld_count;
    logic        w_ld_compare;

    assign w_count_inc  = r_count + 32'd1;
    assign w_ld_count   = i_we && (i_a2 == REG_COUNT);
    assign w_ld_compare = i_we && (i_a2 == REG_COMPARE);

    // Count/Compare registers and the match-pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_pending <= 1'b0;
        end else begin
            r_count <= w_ld_count ? i_din : w_count_inc;
            if (w_ld_compare)
                r_compare <= i_din;
            // Compare write acknowledges the interrupt and wins over a match
            if (w_ld_compare)
                r_pending <= 1'b0;
            else if (!w_ld_count && (w_count_inc == r_compare))
                r_pending <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: Status, Cause, EPC, PRId, interrupt latching and request.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:2] pc,
    input  logic [6:2]  exccode,
    input  logic [7:2]  hwint,
    input  logic        exlSet,
    input  logic        exlClr,
    output logic        intReq,
    output logic [31:2] epc,
    output logic [31:0] dout
);

    exl_state_t  r_state;
    exl_state_t  w_state_nxt;
    logic [5:0]  r_im;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic [29:0] r_epc;
    logic [4:0]  r_exccode;
    logic        w_exl;
    logic        w_we;
    logic        w_tpend;

    // Entry/return strobes own the cycle; a coinciding mtc0 is dropped
    assign w_we  = we & ~exlSet & ~exlClr;
    assign w_exl = (r_state == ST_EXC);

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_a2      (a2),
        .i_din     (din),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_pending (w_tpend)
    );
`else
    assign w_tpend = 1'b0;
`endif

    // EXL next state: entry > return > software write of Status.EXL
    always_comb begin
        w_state_nxt = r_state;
        if (exlSet)
            w_state_nxt = ST_EXC;
        else if (exlClr)
            w_state_nxt = ST_NORMAL;
        else if (w_we && (a2 == REG_SR))
            w_state_nxt = din[SR_EXL] ? ST_EXC : ST_NORMAL;
    end

    // EXL state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_NORMAL;
        else
            r_state <= w_state_nxt;
    end

    // Status IM/IE, EPC and ExcCode updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_im      <= 6'h0;
            r_ie      <= 1'b0;
            r_epc     <= 30'h0;
            r_exccode <= 5'h0;
        end else begin
            if (exlSet) begin
                r_epc     <= pc;
                r_exccode <= exccode;
            end else if (w_we && (a2 == REG_EPC)) begin
                r_epc <= din[31:2];
            end
            if (w_we && (a2 == REG_SR)) begin
                r_im <= din[SR_IM_HI:SR_IM_LO];
                r_ie <= din[SR_IE];
            end
        end
    end

    // Interrupt-pending lines sampled every cycle; timer shares IP7
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ip <= 6'h0;
        else
            r_ip <= {hwint[7] | w_tpend, hwint[6:2]};
    end

    assign intReq = (|(r_ip & r_im)) & r_ie & ~w_exl;
    assign epc    = r_epc;

    // Combinational read mux; same-cycle writes are not forwarded
    always_comb begin
        dout = 32'h0;
        case (a1)
            REG_SR:      dout = pack_status(r_im, w_exl, r_ie);
            REG_CAUSE:   dout = pack_cause(r_ip, r_exccode);
            REG_EPC:     dout = {r_epc, 2'b00};
            REG_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   dout = w_count;
            REG_COMPARE: dout = w_compare;
`endif
            default:     dout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0. Timer scenario compiles in when
// CP0_TIMER_EN is defined; otherwise the disabled-timer behaviour is checked.
module tb_cp0;

    logic        clk, rst, we, exlSet, exlClr, intReq;
    logic [4:0]  a1, a2;
    logic [31:0] din, dout;
    logic [31:2] pc, epc;
    logic [6:2]  exccode;
    logic [7:2]  hwint;

    int checks = 0;
    int failures = 0;

    cp0 dut (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .din(din), .we(we),
        .pc(pc), .exccode(exccode), .hwint(hwint), .exlSet(exlSet),
        .exlClr(exlClr), .intReq(intReq), .epc(epc), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        a2 = a; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        a1 = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rd(5'd12);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_sr got=%h exp=%h", dout, 32'h0); end
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL reset_intreq got=%b exp=0", intReq); end
        checks++; if (epc !== 30'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
        rst = 1'b0;
        tick();
        rd(5'd13);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", dout); end
        rd(5'd14);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_epcrd got=%h exp=0", dout); end
        rd(5'd15);
        checks++; if (dout !== 32'h0000_4D50) begin failures++; $display("FAIL prid got=%h exp=00004d50", dout); end
        rd(5'd3);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL other_idx got=%h exp=0", dout); end
    endtask

    task automatic test_status_rw();
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12);
        checks++; if (dout !== 32'h0000_FC03) begin failures++; $display("FAIL sr_mask got=%h exp=0000fc03", dout); end
        mtc0(5'd12, 32'h0);
        rd(5'd12);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL sr_clear got=%h exp=0", dout); end
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001;
        #1;
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL int_prelatch got=%b exp=0", intReq); end
        tick();
        checks++; if (intReq !== 1'b1) begin failures++; $display("FAIL int_raise got=%b exp=1", intReq); end
        rd(5'd13);
        checks++; if (dout !== 32'h0000_0400) begin failures++; $display("FAIL cause_ip2 got=%h exp=00000400", dout); end
        mtc0(5'd12, 32'h0000_0801);
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL int_masked got=%b exp=0", intReq); end
        mtc0(5'd12, 32'h0000_0400);
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL int_ie_off got=%b exp=0", intReq); end
        mtc0(5'd12, 32'h0000_0401);
        checks++; if (intReq !== 1'b1) begin failures++; $display("FAIL int_reenable got=%b exp=1", intReq); end
    endtask

    task automatic test_exception();
        exlSet = 1'b1; pc = 30'h0000_0C05; exccode = 5'd12;
        tick();
        exlSet = 1'b0;
        checks++; if (epc !== 30'h0000_0C05) begin failures++; $display("FAIL exc_epc got=%h exp=00000c05", epc); end
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL exc_intreq got=%b exp=0", intReq); end
        rd(5'd13);
        checks++; if (dout !== 32'h0000_0430) begin failures++; $display("FAIL exc_cause got=%h exp=00000430", dout); end
        rd(5'd12);
        checks++; if (dout !== 32'h0000_0403) begin failures++; $display("FAIL exc_sr got=%h exp=00000403", dout); end
        exlSet = 1'b1; pc = 30'h0000_0111; exccode = 5'd4;
        tick();
        exlSet = 1'b0;
        checks++; if (epc !== 30'h0000_0111) begin failures++; $display("FAIL nest_epc got=%h exp=00000111", epc); end
        exlClr = 1'b1;
        tick();
        exlClr = 1'b0;
        rd(5'd12);
        checks++; if (dout !== 32'h0000_0401) begin failures++; $display("FAIL eret_sr got=%h exp=00000401", dout); end
        checks++; if (intReq !== 1'b1) begin failures++; $display("FAIL eret_intreq got=%b exp=1", intReq); end
        checks++; if (epc !== 30'h0000_0111) begin failures++; $display("FAIL eret_epc got=%h exp=00000111", epc); end
        rd(5'd13);
        checks++; if (dout !== 32'h0000_0410) begin failures++; $display("FAIL eret_cause got=%h exp=00000410", dout); end
    endtask

    task automatic test_priority();
        exlSet = 1'b1; pc = 30'h0000_0D00; exccode = 5'd0;
        we = 1'b1; a2 = 5'd14; din = 32'h0000_3000;
        tick();
        exlSet = 1'b0; we = 1'b0;
        checks++; if (epc !== 30'h0000_0D00) begin failures++; $display("FAIL prio_set_epc got=%h exp=00000d00", epc); end
        exlClr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0;
        tick();
        exlClr = 1'b0; we = 1'b0;
        rd(5'd12);
        checks++; if (dout !== 32'h0000_0401) begin failures++; $display("FAIL prio_clr_sr got=%h exp=00000401", dout); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13);
        checks++; if (dout !== 32'h0000_0400) begin failures++; $display("FAIL cause_ro got=%h exp=00000400", dout); end
        a1 = 5'd14; we = 1'b1; a2 = 5'd14; din = 32'h1234_5677;
        #1;
        checks++; if (dout !== 32'h0000_3400) begin failures++; $display("FAIL rd_old got=%h exp=00003400", dout); end
        tick();
        we = 1'b0;
        checks++; if (dout !== 32'h1234_5674) begin failures++; $display("FAIL epc_wr_rd got=%h exp=12345674", dout); end
        checks++; if (epc !== 30'h048D_159D) begin failures++; $display("FAIL epc_wr got=%h exp=048d159d", epc); end
    endtask

    task automatic test_reset_exc();
        hwint = 6'b0;
        exlSet = 1'b1; pc = 30'h0000_0077; exccode = 5'd10;
        tick();
        exlSet = 1'b0;
        rd(5'd12);
        checks++; if (dout !== 32'h0000_0403) begin failures++; $display("FAIL rexc_pre got=%h exp=00000403", dout); end
        rst = 1'b1;
        #1;
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rexc_sr got=%h exp=0", dout); end
        checks++; if (epc !== 30'h0) begin failures++; $display("FAIL rexc_epc got=%h exp=0", epc); end
        rd(5'd13);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rexc_cause got=%h exp=0", dout); end
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        int n;
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        n = 0;
        while (!intReq && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n < 19 || n > 21) begin failures++; $display("FAIL timer_latency got=%0d exp=19..21", n); end
        rd(5'd13);
        checks++; if (dout !== 32'h0000_8000) begin failures++; $display("FAIL timer_ip7 got=%h exp=00008000", dout); end
        mtc0(5'd11, 32'd1000);
        tick();
        checks++; if (intReq !== 1'b0) begin failures++; $display("FAIL timer_ack got=%b exp=0", intReq); end
        rd(5'd11);
        checks++; if (dout !== 32'd1000) begin failures++; $display("FAIL compare_rd got=%h exp=000003e8", dout); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9);
        checks++; if (dout !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_load got=%h exp=ffffffff", dout); end
        tick();
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL count_wrap got=%h exp=0", dout); end
    endtask
`else
    task automatic test_timer();
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd7);
        rd(5'd9);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL count_absent got=%h exp=0", dout); end
        rd(5'd11);
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL compare_absent got=%h exp=0", dout); end
    endtask
`endif

    initial begin
        rst = 1'b1; we = 1'b0; exlSet = 1'b0; exlClr = 1'b0;
        a1 = 5'd0; a2 = 5'd0; din = 32'h0; pc = 30'h0; exccode = 5'd0; hwint = 6'b0;
        test_reset();
        test_status_rw();
        test_interrupt();
        test_exception();
        test_priority();
        test_reset_exc();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the multicycle MIPS core: holds Status, Cause, EPC and PRId, latches hardware interrupt lines, and raises the interrupt request. It is the producer side of the exception-redirect path. On exception entry it captures the victim PC into EPC. It drives `epc` back to the next-PC logic, which uses it for `eret`. The controller drives the entry/return strobes and the `mfc0`/`mtc0` traffic.

## Interface
- `PRID`, 32'h0000_4D50, constant returned for register 15.
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `a1` input 5 — read register select (`mfc0` rd).
- `a2` input 5 — write register select (`mtc0` rd).
- `din` input 32 — write data (`mtc0` rt value).
- `we` input 1 — write strobe for `mtc0`.
- `pc` input [31:2] — PC of the victim instruction.
- `exccode` input [6:2] — cause code supplied by the controller (0 = Int, 4 = AdEL, 10 = RI, 12 = Ov).
- `hwint` input [7:2] — level-sensitive hardware interrupt lines.
- `exlSet` input 1 — exception/interrupt entry strobe.
- `exlClr` input 1 — `eret` strobe.
- `intReq` output 1 — interrupt request to the controller.
- `epc` output [31:2] — EPC register contents.
- `dout` output 32 — read data.

## Operation
- **Status (12).**
  - Fields: IM[15:10], EXL[1], IE[0]; every other bit reads 0.
  - Writable by `mtc0`.
- **Cause (13).**
  - Fields: IP[15:10] and ExcCode[6:2]; every other bit reads 0.
  - Read-only to `mtc0`; writes to it are ignored.
  - IP is registered every cycle from `hwint` (IP7 also ORs in the timer pending bit when the timer is enabled).
- **EPC (14).** Writable by `mtc0` with `din[31:2]`; reads as {EPC, 2'b00}.
- **PRId (15).** Reads `PRID`.
- **Other indices.** Read 0; writes are ignored.
- **Interrupt request.** `intReq` = |(IP & IM) & IE & ~EXL, combinational from the registers.
- **EXL state machine.**
  - States: NORMAL (EXL=0) and EXC (EXL=1).
  - `exlSet` in either state: EPC ← `pc`, ExcCode ← `exccode`, EXL ← 1. Nested entry overwrites EPC.
  - `exlClr`: EXL ← 0. No other field changes.
- **Priority within one cycle:** `exlSet` > `exlClr` > `we`.
  - A `mtc0` coinciding with `exlSet` or `exlClr` is discarded entirely.
- **Read port.** `dout` is combinational from `a1`. A read in the same cycle as a write to the same register returns the old value.

## Timing
- **Reset values:** Status, Cause, EPC, IP and timer registers = 0; `intReq` = 0; `epc` = 0; `dout` = the `a1` mux over the reset state.
- **`hwint` → `intReq`:** 1 cycle (IP registered first, then combinational).
- **`exlSet`:** `epc` and EXL are updated at the same edge. `intReq` drops in the cycle after `exlSet`.
- **`exlClr`:** `intReq` may reassert in the following cycle if IP & IM is still nonzero.
- **`mtc0`:** takes effect at the edge where `we` is sampled. `intReq` reflects the new IM/IE in the next cycle.
- **Reset during EXC:** returns immediately to NORMAL with all registers cleared.

## Configuration
- Macro: `CP0_TIMER_EN`.
- **Defined:**
  - Count (9) increments every cycle and wraps from 32'hFFFF_FFFF to 0.
  - Compare (11) is writable.
  - When Count == Compare after an increment, the pending bit is set.
  - The pending bit ORs into IP7.
  - An `mtc0` to Compare clears the pending bit.
  - An `mtc0` to Count loads Count; that cycle's increment is suppressed.
- **Undefined:** indices 9 and 11 read 0, writes to them are ignored, and IP7 = `hwint[7]` only.

## Structure
- Shared package `cp0_pkg`:
  - Register index constants (9, 11, 12, 13, 14, 15).
  - ExcCode constants (INT, ADEL, RI, OV).
  - Status/Cause field bit positions.
- One sub-module: `cp0_timer` (Count, Compare, pending bit). Instantiated only under `CP0_TIMER_EN`.

## Test plan
- **Reset and PRId:** reset, then read index 12, 13 and 14 → 0. Read index 15 → 32'h0000_4D50.
- **Interrupt request:** `mtc0` Status = 32'h0000_0401, then hold `hwint` = 6'b000001 → IP2 = 1, and `intReq` = 1 one cycle after IP is latched.
- **Exception entry and return:**
  - `exlSet` with `pc` = 30'h0000_0C05 and `exccode` = 12 → `epc` = 30'h0000_0C05, Cause[6:2] = 12, EXL = 1, `intReq` = 0.
  - `exlClr` → EXL = 0, and `intReq` returns.
- **Priority:** `we` to EPC (`din` = 32'h0000_3000) in the same cycle as `exlSet` (`pc` = 30'h0000_0D00) → `epc` = 30'h0000_0D00. A Cause write → no change.
- **Timer (`CP0_TIMER_EN`):**
  - Compare = 20, Count = 0, Status = 32'h0000_8001 → `intReq` rises about 21 cycles later.
  - Writing Compare clears it.
  - Count = 32'hFFFF_FFFF wraps to 0.
